// File: rtl/ibram_read_sequencer.sv
// ---------------------------------------------------------------------------
// ibram_read_sequencer
//
// Activation-read sequencer between the double-buffered input BRAM and the
// PE array's activation port. Each layer starts with one parameter word. The
// block then waits for the current ping-pong half to be written. It replays
// the activation tiles once per output-channel tile, in either loop order.
// Reads are issued in lock-step with the weight reader. A small skid FIFO,
// guarded by read credits, absorbs the BRAM read latency.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   param_data/valid/ready         layer parameter word input (handshake)
//   param_s_data/valid/ready       parameter word forwarded to the south reader
//   buf_full[1:0]                  half h has been fully written
//   buf_release[1:0]               one-cycle pulse: half h consumed
//   enB, addrB                     BRAM read enable, {half, word address}
//   doB                            BRAM read data, BRAM_LAT cycles after enB
//   wrd_ready                      weight reader is ready to issue a beat
//   ird_ready                      this block is ready to issue a beat
//   act_data/valid/last/ready      activation stream to the PEs
//
// Parameter word fields: [31] last_layer, [30] oc_first, [29:22] oc_tiles,
// [21:14] act_tiles, [11:0] accum_total. A field value of 0 means 1.
// ---------------------------------------------------------------------------
module ibram_read_sequencer #(
  parameter int NUM_BANKS   = 4,
  parameter int ACT_WIDTH   = 8,
  parameter int HALF_DEPTH  = 512,
  parameter int BRAM_LAT    = 1,
  parameter int PARAM_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PARAM_WIDTH-1:0]         param_data,
  input  logic                           param_valid,
  output logic                           param_ready,
  output logic [PARAM_WIDTH-1:0]         param_s_data,
  output logic                           param_s_valid,
  input  logic                           param_s_ready,
  input  logic [1:0]                     buf_full,
  output logic [1:0]                     buf_release,
  output logic                           enB,
  output logic [$clog2(HALF_DEPTH):0]    addrB,
  input  logic [NUM_BANKS*ACT_WIDTH-1:0] doB,
  input  logic                           wrd_ready,
  output logic                           ird_ready,
  output logic [NUM_BANKS*ACT_WIDTH-1:0] act_data,
  output logic                           act_valid,
  output logic                           act_last,
  input  logic                           act_ready
);

  localparam int W     = NUM_BANKS * ACT_WIDTH;
  localparam int AW    = $clog2(HALF_DEPTH);
  localparam int DEPTH = BRAM_LAT + 2;          // skid FIFO depth = credit pool
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARAM,
    S_WAIT_BUF,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic              r_rd_half;
  logic [PARAM_WIDTH-1:0] r_param;              // latched word, also forwarded south
  logic              r_param_s_valid;
  logic [1:0]        r_buf_release;

  logic [11:0]       r_accum;
  logic [7:0]        r_act_tile;
  logic [7:0]        r_oc_tile;
  logic [AW-1:0]     r_act_base;                // act_tile * accum_total, kept incrementally

  logic [CW-1:0]     r_credits;
  logic [BRAM_LAT-1:0] r_vpipe;                 // read-in-flight flags
  logic [BRAM_LAT-1:0] r_lpipe;                 // act_last flags riding with the reads

  logic [W-1:0]      r_mem [DEPTH];
  logic [DEPTH-1:0]  r_mem_last;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  // Field decode from the latched parameter word.
  logic [7:0]        w_oc_field, w_act_field, w_oc_max, w_act_max;
  logic [11:0]       w_acc_field, w_acc_total, w_acc_max;
  logic              w_last_layer, w_oc_first;
  logic              w_last_acc, w_last_act, w_last_oc, w_final;
  logic              w_issue, w_pop, w_push, w_param_hs;
  logic [AW-1:0]     w_addr;
  logic [PW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt;

  assign w_last_layer = r_param[31];
  assign w_oc_first   = r_param[30];
  assign w_oc_field   = r_param[29:22];
  assign w_act_field  = r_param[21:14];
  assign w_acc_field  = r_param[11:0];
  assign w_oc_max     = (w_oc_field  == 8'd0)  ? 8'd0  : w_oc_field  - 8'd1;
  assign w_act_max    = (w_act_field == 8'd0)  ? 8'd0  : w_act_field - 8'd1;
  assign w_acc_total  = (w_acc_field == 12'd0) ? 12'd1 : w_acc_field;
  assign w_acc_max    = w_acc_total - 12'd1;

  assign w_last_acc = (r_accum    == w_acc_max);
  assign w_last_act = (r_act_tile == w_act_max);
  assign w_last_oc  = (r_oc_tile  == w_oc_max);
  assign w_final    = w_last_acc & w_last_act & w_last_oc;

  assign w_addr = r_act_base + AW'(r_accum);

  // Handshakes and issue.
  assign param_ready = (r_state == S_PARAM) & ~r_param_s_valid;
  assign w_param_hs  = param_valid & param_ready;
  assign ird_ready   = (r_state == S_STREAM) & (r_credits != '0);
  assign w_issue     = ird_ready & wrd_ready;
  assign enB         = w_issue;
  assign addrB       = {r_rd_half, w_addr};

  assign param_s_data  = r_param;
  assign param_s_valid = r_param_s_valid;
  assign buf_release   = r_buf_release;

  // FIFO head drives the activation port; data is forced to 0 when empty so
  // the port is clean after reset even though the storage is not reset.
  assign act_valid = (r_count != '0);
  assign act_data  = act_valid ? r_mem[r_rd_ptr] : '0;
  assign act_last  = act_valid & r_mem_last[r_rd_ptr];
  assign w_pop     = act_valid & act_ready;
  assign w_push    = r_vpipe[BRAM_LAT-1];

  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  // -------------------------------------------------------------------------
  // Control FSM and loop counters
  // -------------------------------------------------------------------------
  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values; a blocking update here would let later
  // statements see the new value and change the logic that is built.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_rd_half       <= 1'b0;
      r_param         <= '0;
      r_param_s_valid <= 1'b0;
      r_buf_release   <= 2'b00;
      r_accum         <= '0;
      r_act_tile      <= '0;
      r_oc_tile       <= '0;
      r_act_base      <= '0;
    end else begin
      r_buf_release <= 2'b00;
      if (r_param_s_valid && param_s_ready) r_param_s_valid <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (param_valid) r_state <= S_PARAM;
        end
        S_PARAM: begin
          if (w_param_hs) begin
            r_param         <= param_data;
            r_param_s_valid <= 1'b1;
            r_state         <= S_WAIT_BUF;
          end
        end
        S_WAIT_BUF: begin
          if (buf_full[r_rd_half]) r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_issue) begin
            if (!w_last_acc) begin
              r_accum <= r_accum + 12'd1;
            end else begin
              r_accum <= '0;
              if (!w_oc_first) begin
                // act_tile is the middle loop, oc_tile the outer one.
                if (!w_last_act) begin
                  r_act_tile <= r_act_tile + 8'd1;
                  r_act_base <= r_act_base + AW'(w_acc_total);
                end else begin
                  r_act_tile <= '0;
                  r_act_base <= '0;
                  r_oc_tile  <= w_last_oc ? 8'd0 : r_oc_tile + 8'd1;
                end
              end else begin
                // oc_tile is the middle loop, act_tile the outer one.
                if (!w_last_oc) begin
                  r_oc_tile <= r_oc_tile + 8'd1;
                end else begin
                  r_oc_tile <= '0;
                  if (!w_last_act) begin
                    r_act_tile <= r_act_tile + 8'd1;
                    r_act_base <= r_act_base + AW'(w_acc_total);
                  end else begin
                    r_act_tile <= '0;
                    r_act_base <= '0;
                  end
                end
              end
            end
            if (w_final) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Release only once the last read has landed in the FIFO.
          if (r_vpipe == '0) begin
            r_buf_release[r_rd_half] <= 1'b1;
            r_rd_half                <= ~r_rd_half;
            r_state                  <= w_last_layer ? S_IDLE : S_PARAM;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read credits: one per FIFO slot, taken on issue, returned on pop.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= CW'(DEPTH);
    end else begin
      unique case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // BRAM latency pipe: valid and last flags travel with each read.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vpipe <= '0;
      r_lpipe <= '0;
    end else begin
      r_vpipe[0] <= w_issue;
      r_lpipe[0] <= w_issue & w_last_acc;
      for (int i = 1; i < BRAM_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_lpipe[i] <= r_lpipe[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Skid FIFO. Credits guarantee it never overflows.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the reset
  // pointers/count and the output is masked while empty, so resetting the
  // array would only cost flops and block RAM/LUTRAM mapping.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]      <= doB;
      r_mem_last[r_wr_ptr] <= r_lpipe[BRAM_LAT-1];
    end
  end

endmodule

// File: tb/tb_ibram_read_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for ibram_read_sequencer (BRAM_LAT = 3, FIFO/credit depth 5).
// A BRAM model returns a known word per {half, address}. The expected issue
// order is generated from the layer parameters with plain nested loops. A
// single negedge compare process checks every issue, every popped word, the
// forwarded parameter words and the in-flight bound. Directed tests add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ibram_read_sequencer;

  localparam int NUM_BANKS   = 4;
  localparam int ACT_WIDTH   = 8;
  localparam int HALF_DEPTH  = 512;
  localparam int BRAM_LAT    = 3;
  localparam int PARAM_WIDTH = 32;
  localparam int W           = NUM_BANKS * ACT_WIDTH;
  localparam int AW          = $clog2(HALF_DEPTH);
  localparam int DEPTH       = BRAM_LAT + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      param_data = '0;
  logic             param_valid = 1'b0;
  logic             param_ready;
  logic [31:0]      param_s_data;
  logic             param_s_valid;
  logic             param_s_ready = 1'b1;
  logic [1:0]       buf_full = 2'b00;
  logic [1:0]       buf_release;
  logic             enB;
  logic [AW:0]      addrB;
  logic [W-1:0]     doB;
  logic             wrd_ready = 1'b1;
  logic             ird_ready;
  logic [W-1:0]     act_data;
  logic             act_valid;
  logic             act_last;
  logic             act_ready = 1'b1;

  ibram_read_sequencer #(
    .NUM_BANKS  (NUM_BANKS),
    .ACT_WIDTH  (ACT_WIDTH),
    .HALF_DEPTH (HALF_DEPTH),
    .BRAM_LAT   (BRAM_LAT),
    .PARAM_WIDTH(PARAM_WIDTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .param_data   (param_data),
    .param_valid  (param_valid),
    .param_ready  (param_ready),
    .param_s_data (param_s_data),
    .param_s_valid(param_s_valid),
    .param_s_ready(param_s_ready),
    .buf_full     (buf_full),
    .buf_release  (buf_release),
    .enB          (enB),
    .addrB        (addrB),
    .doB          (doB),
    .wrd_ready    (wrd_ready),
    .ird_ready    (ird_ready),
    .act_data     (act_data),
    .act_valid    (act_valid),
    .act_last     (act_last),
    .act_ready    (act_ready)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  typedef struct packed {
    logic [AW:0] addr;
    logic        last;
  } beat_t;

  beat_t       iss_q[$];
  beat_t       out_q[$];
  logic [31:0] fwd_q[$];
  int          obs_addr[$];

  logic chk_en  = 1'b0;
  logic bp_mode = 1'b0;
  int   cyc = 0;
  int   n_issued, n_last, n_stall, rel_cnt, in_flight;
  int   first_issue, first_valid, last_issue;
  logic [1:0]   rel_val;
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_data;

  function automatic logic [W-1:0] bram_word(input logic [AW:0] a);
    return 32'h5A00_0000 + 32'(a) * 32'd257;
  endfunction

  // ---------------- BRAM model ----------------
  logic [W-1:0] bram_pipe [BRAM_LAT];
  always @(posedge clk) begin
    bram_pipe[0] <= enB ? bram_word(addrB) : 32'hDEAD_BEEF;
    for (int i = 1; i < BRAM_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign doB = bram_pipe[BRAM_LAT-1];

  // act_ready: high, or toggling every cycle in backpressure mode.
  initial forever begin
    @(posedge clk);
    #1;
    act_ready = bp_mode ? ~act_ready : 1'b1;
  end

  // ---------------- reference model ----------------
  task automatic model_layer(input logic [31:0] pw, input logic half);
    int oc_n, act_n, tot, outer_n, mid_n, act;
    beat_t b;
    oc_n    = (pw[29:22] == 8'd0)  ? 1 : int'(pw[29:22]);
    act_n   = (pw[21:14] == 8'd0)  ? 1 : int'(pw[21:14]);
    tot     = (pw[11:0]  == 12'd0) ? 1 : int'(pw[11:0]);
    outer_n = pw[30] ? act_n : oc_n;
    mid_n   = pw[30] ? oc_n  : act_n;
    for (int o = 0; o < outer_n; o++)
      for (int m = 0; m < mid_n; m++)
        for (int k = 0; k < tot; k++) begin
          act    = pw[30] ? o : m;
          b.addr = {half, AW'(act * tot + k)};
          b.last = (k == tot - 1);
          iss_q.push_back(b);
          out_q.push_back(b);
        end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    beat_t e;
    logic [31:0] fw;
    cyc++;
    if (rst_n && chk_en) begin
      if (enB) begin
        check("enB_without_wrd_ready", wrd_ready, 1);
        check("enB_before_buf_full", buf_full[addrB[AW]], 1);
        check("issue_expected", iss_q.size() != 0, 1);
        if (iss_q.size() != 0) begin
          e = iss_q.pop_front();
          check("addrB", addrB, e.addr);
        end
        obs_addr.push_back(int'(addrB));
        n_issued++;
        in_flight++;
        if (first_issue < 0) first_issue = cyc;
        last_issue = cyc;
      end
      if (act_valid && first_valid < 0) first_valid = cyc;
      if (hold_pending) begin
        check("act_valid_held", act_valid, 1);
        check("act_data_held", act_data, hold_data);
      end
      if (act_valid && act_ready) begin
        check("word_expected", out_q.size() != 0, 1);
        if (out_q.size() != 0) begin
          e = out_q.pop_front();
          check("act_data", act_data, bram_word(e.addr));
          check("act_last", act_last, e.last);
        end
        in_flight--;
        if (act_last) n_last++;
      end
      hold_pending = act_valid && !act_ready;
      hold_data    = act_data;
      if (hold_pending) n_stall++;
      check("in_flight_bound", in_flight <= DEPTH, 1);
      if (buf_release != 2'b00) begin
        rel_cnt++;
        rel_val = buf_release;
      end
      if (param_s_valid && param_s_ready) begin
        check("fwd_expected", fwd_q.size() != 0, 1);
        if (fwd_q.size() != 0) begin
          fw = fwd_q.pop_front();
          check("param_s_data", param_s_data, fw);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_stats();
    n_issued = 0; n_last = 0; n_stall = 0; rel_cnt = 0; rel_val = 2'b00;
    first_issue = -1; first_valid = -1; last_issue = -1;
    obs_addr.delete();
  endtask

  task automatic prep_layer(input logic [31:0] pw, input logic half);
    model_layer(pw, half);
    clear_stats();
    fwd_q.push_back(pw);
  endtask

  task automatic offer_param(input logic [31:0] pw);
    bit ok = 0;
    @(posedge clk); #1;
    param_data  = pw;
    param_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (param_ready) begin ok = 1; break; end
    end
    check("param_handshake_in_time", ok, 1);
    @(posedge clk); #1;
    param_valid = 1'b0;
  endtask

  task automatic wait_layer_done(input logic [1:0] exp_rel);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rel_cnt > 0 && out_q.size() == 0 && in_flight == 0) begin ok = 1; break; end
    end
    check("layer_done_in_time", ok, 1);
    repeat (3) @(negedge clk);
    check("release_pulse_count", rel_cnt, 1);
    check("release_half", rel_val, exp_rel);
    check("all_issues_seen", iss_q.size(), 0);
  endtask

  task automatic wait_issued(input int n);
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (n_issued >= n) begin ok = 1; break; end
    end
    check("issues_started_in_time", ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enB"}, enB, 0);
    check({tag, "_addrB"}, addrB, 0);
    check({tag, "_act_valid"}, act_valid, 0);
    check({tag, "_act_data"}, act_data, 0);
    check({tag, "_act_last"}, act_last, 0);
    check({tag, "_param_ready"}, param_ready, 0);
    check({tag, "_param_s_valid"}, param_s_valid, 0);
    check({tag, "_param_s_data"}, param_s_data, 0);
    check({tag, "_buf_release"}, buf_release, 0);
    check({tag, "_ird_ready"}, ird_ready, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [31:0] pw, pw_a, pw_b;
    int exp_ocf [24] = '{0,1,2,3, 0,1,2,3, 4,5,6,7, 4,5,6,7, 8,9,10,11, 8,9,10,11};
    in_flight = 0;
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: oc_first=0, oc 2, act 3, accum 4, half 0.
    pw = {1'b1, 1'b0, 8'd2, 8'd3, 2'b00, 12'd4};
    buf_full = 2'b01;
    prep_layer(pw, 1'b0);
    offer_param(pw);
    wait_layer_done(2'b01);
    check("t1_word_count", obs_addr.size(), 24);
    for (int i = 0; i < 24 && i < obs_addr.size(); i++) check("t1_addr_literal", obs_addr[i], i % 12);
    check("t1_last_count", n_last, 6);
    check("t1_read_latency", first_valid - first_issue, 4);
    check("t1_back_to_back", last_issue - first_issue, 23);
    check("t1_idle_param_ready", param_ready, 0);
    check("t1_idle_ird_ready", ird_ready, 0);
    buf_full = 2'b00;

    // 2: same layer, oc_first=1, now on half 1.
    pw = {1'b1, 1'b1, 8'd2, 8'd3, 2'b00, 12'd4};
    buf_full = 2'b10;
    prep_layer(pw, 1'b1);
    offer_param(pw);
    wait_layer_done(2'b10);
    check("t2_word_count", obs_addr.size(), 24);
    for (int i = 0; i < 24 && i < obs_addr.size(); i++) check("t2_addr_literal", obs_addr[i], 512 + exp_ocf[i]);
    buf_full = 2'b00;

    // 3: backpressure, act_ready toggling.
    pw = {1'b1, 1'b0, 8'd2, 8'd2, 2'b00, 12'd5};
    buf_full = 2'b01;
    bp_mode  = 1'b1;
    prep_layer(pw, 1'b0);
    offer_param(pw);
    wait_layer_done(2'b01);
    check("t3_word_count", obs_addr.size(), 20);
    check("t3_stalls_seen", n_stall > 0, 1);
    bp_mode  = 1'b0;
    buf_full = 2'b00;

    // 4: weight reader stalls for 10 cycles mid-stream.
    pw = {1'b1, 1'b0, 8'd1, 8'd2, 2'b00, 12'd8};
    buf_full = 2'b10;
    prep_layer(pw, 1'b1);
    offer_param(pw);
    wait_issued(5);
    @(posedge clk); #1;
    wrd_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("t4_enB_low_while_stalled", enB, 0);
    end
    @(posedge clk); #1;
    wrd_ready = 1'b1;
    wait_layer_done(2'b10);
    check("t4_word_count", obs_addr.size(), 16);
    if (obs_addr.size() > 5) check("t4_resume_addr", obs_addr[5], 512 + 5);
    buf_full = 2'b00;

    // 5: two layers, south reader not accepting at first.
    pw_a = {1'b0, 1'b0, 8'd2, 8'd1, 2'b00, 12'd3};
    pw_b = {1'b1, 1'b1, 8'd1, 8'd2, 2'b00, 12'd2};
    param_s_ready = 1'b0;
    buf_full = 2'b01;
    prep_layer(pw_a, 1'b0);
    offer_param(pw_a);
    wait_layer_done(2'b01);
    check("t5_first_word_count", obs_addr.size(), 6);
    buf_full = 2'b00;
    check("t5_fwd_valid_held", param_s_valid, 1);
    check("t5_fwd_data_a", param_s_data, pw_a);
    prep_layer(pw_b, 1'b1);
    @(posedge clk); #1;
    param_data  = pw_b;
    param_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t5_param_ready_blocked", param_ready, 0);
      check("t5_fwd_data_stable", param_s_data, pw_a);
    end
    @(posedge clk); #1;
    param_s_ready = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (param_ready) begin ok = 1; break; end
      end
      check("t5_second_handshake", ok, 1);
    end
    @(posedge clk); #1;
    param_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_no_read_before_buf_full", n_issued, 0);
    buf_full = 2'b10;
    wait_layer_done(2'b10);
    check("t5_second_word_count", obs_addr.size(), 4);
    if (obs_addr.size() > 0) check("t5_second_half_addr", obs_addr[0], 512);
    check("t5_fwd_all_seen", fwd_q.size(), 0);
    buf_full = 2'b00;

    // 6: reset mid-stream, then a fresh layer from half 0 address 0.
    pw = {1'b1, 1'b0, 8'd2, 8'd3, 2'b00, 12'd4};
    buf_full = 2'b01;
    prep_layer(pw, 1'b0);
    offer_param(pw);
    wait_issued(6);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    #1;
    check_reset_outputs("mid");
    iss_q.delete();
    out_q.delete();
    fwd_q.delete();
    in_flight    = 0;
    hold_pending = 1'b0;
    clear_stats();
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_no_release_after_reset", rel_cnt, 0);
    pw = {1'b1, 1'b0, 8'd1, 8'd1, 2'b00, 12'd3};
    prep_layer(pw, 1'b0);
    offer_param(pw);
    wait_layer_done(2'b01);
    check("t6_word_count", obs_addr.size(), 3);
    if (obs_addr.size() > 0) check("t6_restart_addr", obs_addr[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
